// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter sharing one SPI controller between two requesters.
// Defining SPI_ARB_TIMEOUT_EN adds a WAIT watchdog and the o_err port.
module spi_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        RST_N,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic [7:0]  i_cfg0,
    input  logic [7:0]  i_cfg1,
    input  logic [7:0]  i_tx0,
    input  logic [7:0]  i_tx1,
    output logic        o_gnt0,
    output logic        o_gnt1,
    output logic        o_done0,
    output logic        o_done1,
    output logic [7:0]  o_rx_byte,
    output logic [31:0] o_data_to_registers,
    output logic        o_wr_controll_reg,
    output logic        o_wr_data_reg,
    output logic        o_read_status_reg,
`ifdef SPI_ARB_TIMEOUT_EN
    output logic        o_err,
`endif
    input  logic        i_irq,
    input  logic [7:0]  i_data_reg
);

    if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("spi_arbiter: TIMEOUT_CYCLES must be in 16..65535");
    end

    typedef enum logic [2:0] {IDLE, CFG, LOAD, WAIT, READ, DONE} state_e;

    state_e     state_q, state_d;
    logic       win_q, win_d;
    logic       last_q, last_d;
    logic [7:0] cfg_q, cfg_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic       timeout;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    assign timeout = cnt_q == TO_LAST;
    // counter is zero on every WAIT entry because it only runs inside WAIT
    assign cnt_d   = (state_q == WAIT) ? cnt_q + 16'd1 : 16'd0;
    assign err_d   = (state_q == WAIT) && !i_irq && timeout;
    assign o_err   = err_q;
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= 16'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (i_req0 || i_req1) ? CFG : IDLE;
            CFG:     state_d = LOAD;
            LOAD:    state_d = WAIT;
            WAIT:    state_d = (i_irq || timeout) ? READ : WAIT;
            READ:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_wr_controll_reg   = state_q == CFG;
        o_wr_data_reg       = state_q == LOAD;
        o_read_status_reg   = state_q == READ;
        o_gnt0              = (state_q != IDLE) && !win_q;
        o_gnt1              = (state_q != IDLE) && win_q;
        o_done0             = (state_q == DONE) && !win_q;
        o_done1             = (state_q == DONE) && win_q;
        o_data_to_registers = (state_q == CFG)  ? {24'b0, cfg_q | 8'h80} :
                              (state_q == LOAD) ? {24'b0, tx_q} : 32'b0;
    end

    assign o_rx_byte = rx_q;

    // on a tie the requester not granted last wins
    always_comb begin
        win_d  = win_q;
        last_d = last_q;
        cfg_d  = cfg_q;
        tx_d   = tx_q;
        rx_d   = (state_q == READ) ? i_data_reg : rx_q;
        if (state_q == IDLE && (i_req0 || i_req1)) begin
            win_d  = (i_req0 && i_req1) ? ~last_q : i_req1;
            last_d = win_d;
            cfg_d  = win_d ? i_cfg1 : i_cfg0;
            tx_d   = win_d ? i_tx1 : i_tx0;
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            win_q  <= 1'b0;
            last_q <= 1'b1;
            cfg_q  <= 8'd0;
            tx_q   <= 8'd0;
            rx_q   <= 8'd0;
        end else begin
            win_q  <= win_d;
            last_q <= last_d;
            cfg_q  <= cfg_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed self-checking bench for spi_arbiter.
// Outputs are packed as {gnt0,gnt1,done0,done1,wr_ctrl,wr_data,rd_status}.
module tb_spi_arbiter;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 4096;
`endif

    logic        clk = 1'b0;
    logic        RST_N = 1'b0;
    logic        i_req0 = 1'b0, i_req1 = 1'b0, i_irq = 1'b0;
    logic [7:0]  i_cfg0 = 8'h0, i_cfg1 = 8'h0, i_tx0 = 8'h0, i_tx1 = 8'h0, i_data_reg = 8'h0;
    logic        o_gnt0, o_gnt1, o_done0, o_done1;
    logic        o_wr_controll_reg, o_wr_data_reg, o_read_status_reg;
    logic [7:0]  o_rx_byte;
    logic [31:0] o_data_to_registers;
`ifdef SPI_ARB_TIMEOUT_EN
    logic        o_err;
`endif

    spi_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .RST_N(RST_N),
        .i_req0(i_req0), .i_req1(i_req1),
        .i_cfg0(i_cfg0), .i_cfg1(i_cfg1),
        .i_tx0(i_tx0), .i_tx1(i_tx1),
        .o_gnt0(o_gnt0), .o_gnt1(o_gnt1),
        .o_done0(o_done0), .o_done1(o_done1),
        .o_rx_byte(o_rx_byte),
        .o_data_to_registers(o_data_to_registers),
        .o_wr_controll_reg(o_wr_controll_reg),
        .o_wr_data_reg(o_wr_data_reg),
        .o_read_status_reg(o_read_status_reg),
`ifdef SPI_ARB_TIMEOUT_EN
        .o_err(o_err),
`endif
        .i_irq(i_irq), .i_data_reg(i_data_reg)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] outs();
        return {25'b0, o_gnt0, o_gnt1, o_done0, o_done1, o_wr_controll_reg, o_wr_data_reg, o_read_status_reg};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dones;
        tick();
        tick();
        check("reset_outs", outs(), 32'h00);
        check("reset_data", o_data_to_registers, 32'h0);
        check("reset_rx", {24'b0, o_rx_byte}, 32'h0);
        RST_N = 1'b1;

        // single transaction from requester 0
        i_req0 = 1'b1; i_cfg0 = 8'h0C; i_tx0 = 8'hA5;
        tick();
        check("t1_cfg_outs", outs(), 32'h44);
        check("t1_cfg_data", o_data_to_registers, 32'h0000008C);
        i_req0 = 1'b0;
        tick();
        check("t1_load_outs", outs(), 32'h42);
        check("t1_load_data", o_data_to_registers, 32'h000000A5);
        tick();
        tick();
        check("t1_wait_outs", outs(), 32'h40);
        check("t1_wait_data", o_data_to_registers, 32'h0);
        i_irq = 1'b1; i_data_reg = 8'h3C;
        tick();
        i_irq = 1'b0;
        check("t1_read_outs", outs(), 32'h41);
        tick();
        check("t1_done_outs", outs(), 32'h50);
        check("t1_rx", {24'b0, o_rx_byte}, 32'h3C);
        tick();
        check("t1_idle_outs", outs(), 32'h00);

        // fresh reset, then both requesters held: order 0,1,0,1
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        i_req0 = 1'b1; i_req1 = 1'b1;
        i_cfg0 = 8'h01; i_cfg1 = 8'h13; i_tx0 = 8'h11; i_tx1 = 8'h22;
        for (int t = 0; t < 4; t++) begin
            tick();
            check($sformatf("rr%0d_cfg_outs", t), outs(), (t % 2) ? 32'h24 : 32'h44);
            check($sformatf("rr%0d_cfg_data", t), o_data_to_registers, (t % 2) ? 32'h93 : 32'h81);
            tick();
            check($sformatf("rr%0d_load_data", t), o_data_to_registers, (t % 2) ? 32'h22 : 32'h11);
            tick();
            i_irq = 1'b1; i_data_reg = 8'(8'h40 + t);
            tick();
            i_irq = 1'b0;
            tick();
            check($sformatf("rr%0d_done_outs", t), outs(), (t % 2) ? 32'h28 : 32'h50);
            check($sformatf("rr%0d_rx", t), {24'b0, o_rx_byte}, 32'h40 + t);
            tick();
            check($sformatf("rr%0d_idle_outs", t), outs(), 32'h00);
        end
        i_req0 = 1'b0; i_req1 = 1'b0;
        tick();

        // requester 1 drops its request during WAIT
        i_req1 = 1'b1;
        tick();
        check("t3_cfg_outs", outs(), 32'h24);
        tick();
        tick();
        i_req1 = 1'b0;
        tick();
        tick();
        check("t3_wait_outs", outs(), 32'h20);
        i_irq = 1'b1; i_data_reg = 8'h77;
        tick();
        i_irq = 1'b0;
        check("t3_read_outs", outs(), 32'h21);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            dones += int'(o_done1);
        end
        check("t3_done1_count", 32'(dones), 32'd1);
        check("t3_rx", {24'b0, o_rx_byte}, 32'h77);

        // asynchronous reset during WAIT
        i_req0 = 1'b1;
        tick();
        i_req0 = 1'b0;
        tick();
        tick();
        tick();
        check("t4_wait_outs", outs(), 32'h40);
        #2 RST_N = 1'b0;
        #1;
        check("t4_rst_outs", outs(), 32'h00);
        check("t4_rst_data", o_data_to_registers, 32'h0);
        check("t4_rst_rx", {24'b0, o_rx_byte}, 32'h0);
        i_irq = 1'b1;
        tick();
        tick();
        RST_N = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            dones += int'(o_done0) + int'(o_done1);
        end
        i_irq = 1'b0;
        check("t4_no_done", 32'(dones), 32'd0);
        check("t4_idle_outs", outs(), 32'h00);

`ifdef SPI_ARB_TIMEOUT_EN
        // watchdog: no irq, o_err 16 cycles after WAIT entry
        i_req0 = 1'b1; i_cfg0 = 8'h0C; i_data_reg = 8'h5A;
        tick();
        i_req0 = 1'b0;
        tick();
        tick();
        check("t5_wait_entry", outs(), 32'h40);
        dones = int'(o_err);
        for (int i = 0; i < 15; i++) begin
            tick();
            dones += int'(o_err);
        end
        check("t5_no_early_err", 32'(dones), 32'd0);
        check("t5_still_wait", outs(), 32'h40);
        tick();
        check("t5_err", {31'b0, o_err}, 32'd1);
        check("t5_read_outs", outs(), 32'h41);
        tick();
        check("t5_err_clear", {31'b0, o_err}, 32'd0);
        check("t5_done_outs", outs(), 32'h50);
        check("t5_rx", {24'b0, o_rx_byte}, 32'h5A);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
